// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared widths, FSM state type and result constants for the
//            sequential restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DVD_W = 16;
  localparam int DVS_W = 8;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam logic [DVD_W-1:0] C_DBZ_QUOT = '1;

endpackage

`default_nettype wire

// File: rtl/div_restoring_step.sv
// ============================================================================
// Module   : div_restoring_step
// Purpose  : One combinational restoring-division iteration (shift, trial
//            subtract, restore-or-keep).
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_restoring_step
  import div_pkg::*;
(
  input  logic [DVS_W:0]   i_pr,
  input  logic             i_bit,
  input  logic [DVS_W-1:0] i_dvs,
  output logic [DVS_W:0]   o_pr,
  output logic             o_qbit
);

  logic [DVS_W+1:0] w_shift;
  logic [DVS_W+1:0] w_trial;

  always_comb begin
    w_shift = {i_pr, i_bit};
    w_trial = w_shift - {2'b00, i_dvs};
    // A clear top bit means the trial difference did not go negative.
    o_qbit  = ~w_trial[DVS_W+1];
    o_pr    = o_qbit ? w_trial[DVS_W:0] : w_shift[DVS_W:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Iterative 16/8 restoring divider, one quotient bit per clock,
//            unsigned or signed (Cont). Optional DIV_UNITY_BYPASS_EN macro
//            short-cuts |B|==1 straight to the fix-up state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Cont,
  input  logic [DVD_W-1:0] A,
  input  logic [DVS_W-1:0] B,
  output logic [DVD_W-1:0] Q,
  output logic [DVS_W-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  div_state_t       r_state;
  logic [DVS_W:0]   r_pr;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             r_ovf;
  logic             r_fin;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [DVD_W-1:0] w_mag_a;
  logic [DVS_W-1:0] w_mag_b;
  logic             w_accept;
  logic [DVS_W:0]   w_pr_nxt;
  logic             w_qbit;

  always_comb begin
    w_neg_a  = Cont & A[DVD_W-1];
    w_neg_b  = Cont & B[DVS_W-1];
    w_mag_a  = w_neg_a ? -A : A;
    w_mag_b  = w_neg_b ? -B : B;
    // r_fin blocks acceptance in the one IDLE cycle before done is issued.
    w_accept = start && (r_state == IDLE) && !r_fin;
  end

  div_restoring_step u_step (
    .i_pr   (r_pr),
    .i_bit  (r_dvd[DVD_W-1]),
    .i_dvs  (r_dvs),
    .o_pr   (w_pr_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pr    <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_fin   <= 1'b0;
      Q       <= '0;
      R       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (r_fin) begin
        Q     <= r_dvd;
        R     <= r_pr[DVS_W-1:0];
        dbz   <= r_dbz;
        ovf   <= r_ovf;
        done  <= 1'b1;
        r_fin <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            busy    <= 1'b1;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_pr    <= '0;
            r_dvs   <= w_mag_b;
            r_dbz   <= (B == '0);
            r_ovf   <= Cont && (A == {1'b1, {(DVD_W-1){1'b0}}}) && (B == '1);
            if (B == '0) begin
              // Raw dividend kept so its low byte can become the remainder.
              r_dvd   <= A;
              r_state <= FIX;
            end
`ifdef DIV_UNITY_BYPASS_EN
            else if (w_mag_b == DVS_W'(1)) begin
              r_dvd   <= w_mag_a;
              r_state <= FIX;
            end
`endif
            else begin
              r_dvd   <= w_mag_a;
              r_cnt   <= CNT_W'(DVD_W);
              r_state <= ITER;
            end
          end
        end

        ITER: begin
          r_pr  <= w_pr_nxt;
          r_dvd <= {r_dvd[DVD_W-2:0], w_qbit};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          if (r_dbz) begin
            r_dvd <= C_DBZ_QUOT;
            r_pr  <= {1'b0, r_dvd[DVS_W-1:0]};
          end else begin
            if (r_neg_q) begin
              r_dvd <= -r_dvd;
            end
            if (r_neg_r) begin
              r_pr <= {1'b0, -r_pr[DVS_W-1:0]};
            end
          end
          r_fin   <= 1'b1;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Purpose  : Directed self-checking bench with an arithmetic reference model
//            and a per-cycle output monitor for seq_restoring_divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        Cont;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_UNITY_BYPASS_EN
  localparam int UNITY_LAT = 2;
`else
  localparam int UNITY_LAT = 18;
`endif

  seq_restoring_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Cont  (Cont),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference arithmetic: plain integer division, C-style truncation.
  function automatic void model(input bit c, input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output bit dz, output bit ov, output int lat);
    int sa, sb, qi, ri;
    sa = 0; sb = 0; qi = 0; ri = 0;
    dz = 0; ov = 0; lat = 18;
    if (b == 8'h00) begin
      q = 16'hFFFF; r = a[7:0]; dz = 1; lat = 2;
    end else if (c) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 1 || sb == -1) lat = UNITY_LAT;
      if (sa == -32768 && sb == -1) begin
        q = 16'h8000; r = 8'h00; ov = 1;
      end else begin
        qi = sa / sb;
        ri = sa % sb;
        q = qi[15:0];
        r = ri[7:0];
      end
    end else begin
      if (b == 8'h01) lat = UNITY_LAT;
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      q = qi[15:0];
      r = ri[7:0];
    end
  endfunction

  // Transaction-level model of the handshake: edge index of accept and done.
  int          edge_n = 0;
  bit          m_valid = 0;
  bit          pend = 0;
  int          due = 0;
  logic [15:0] pq, m_q;
  logic [7:0]  pr, m_r;
  bit          pdz, pov, m_dbz, m_ovf;

  always @(posedge clk) begin
    int lat;
    edge_n++;
    if (rst) begin
      m_valid = 1; pend = 0;
      m_q = 0; m_r = 0; m_dbz = 0; m_ovf = 0;
    end else if (m_valid) begin
      if (pend && edge_n == due) begin
        m_q = pq; m_r = pr; m_dbz = pdz; m_ovf = pov;
      end
      if (pend && edge_n == due + 1) pend = 0;
      if (!pend && start) begin
        model(Cont, A, B, pq, pr, pdz, pov, lat);
        pend = 1;
        due  = edge_n + lat;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_done;
    if (m_valid) begin
      exp_done = pend && (edge_n == due);
      chk("mon_done", {31'b0, done}, {31'b0, exp_done});
      chk("mon_busy", {31'b0, busy}, {31'b0, pend});
      chk("mon_Q", {16'b0, Q}, {16'b0, m_q});
      chk("mon_R", {24'b0, R}, {24'b0, m_r});
      if (exp_done) begin
        chk("mon_dbz", {31'b0, dbz}, {31'b0, m_dbz});
        chk("mon_ovf", {31'b0, ovf}, {31'b0, m_ovf});
      end
    end
  end

  task automatic issue(input bit c, input logic [15:0] a, input logic [7:0] b);
    start = 1'b1; Cont = c; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit got;
    got = 0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat = i + 1;
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input bit c, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er,
                        input bit edz, input bit eov, input int elat);
    int lat;
    @(negedge clk);
    issue(c, a, b);
    wait_done(lat);
    chk("lat", lat, elat);
    chk("Q", {16'b0, Q}, {16'b0, eq});
    chk("R", {24'b0, R}, {24'b0, er});
    chk("dbz", {31'b0, dbz}, {31'b0, edz});
    chk("ovf", {31'b0, ovf}, {31'b0, eov});
  endtask

  task automatic count_dones(input string nm);
    int n;
    n = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n++;
    end
    chk(nm, n, 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; Cont = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_Q", {16'b0, Q}, 32'h0);
    chk("rst_R", {24'b0, R}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_dbz", {31'b0, dbz}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);

    run_op(0, 16'h03E8, 8'h07, 16'h008E, 8'h06, 0, 0, 18);
    run_op(1, 16'hFC18, 8'h07, 16'hFF72, 8'hFA, 0, 0, 18);
    run_op(1, 16'hFC18, 8'hF9, 16'h008E, 8'hFA, 0, 0, 18);
    run_op(0, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 0, 0, 18);
    run_op(1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 0, 1, UNITY_LAT);
    run_op(0, 16'h8000, 8'hFF, 16'h0080, 8'h80, 0, 0, 18);
    run_op(0, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1, 0, 2);
    run_op(1, 16'h8234, 8'h00, 16'hFFFF, 8'h34, 1, 0, 2);
    run_op(1, 16'h1234, 8'h01, 16'h1234, 8'h00, 0, 0, UNITY_LAT);
    run_op(0, 16'h0005, 8'h09, 16'h0000, 8'h05, 0, 0, 18);

    // Start pulse mid-iteration must be ignored.
    @(negedge clk);
    issue(0, 16'h03E8, 8'h07);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; A = 16'h0100; B = 8'h02;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("ign_lat", lat + 6, 18);
    chk("ign_Q", {16'b0, Q}, 32'h008E);
    chk("ign_R", {24'b0, R}, 32'h06);
    count_dones("ign_single_done");

    // Back-to-back: new start in the done cycle is accepted.
    run_op(1, 16'hFC18, 8'hF9, 16'h008E, 8'hFA, 0, 0, 18);
    issue(1, 16'h0007, 8'hFE);
    wait_done(lat);
    chk("b2b_lat", lat, 18);
    chk("b2b_Q", {16'b0, Q}, 32'hFFFD);
    chk("b2b_R", {24'b0, R}, 32'h01);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    issue(0, 16'hFFFF, 8'h0F);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_Q", {16'b0, Q}, 32'h0);
    chk("abort_R", {24'b0, R}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    count_dones("abort_no_done");
    run_op(0, 16'hFFFE, 8'h0F, 16'h1110, 8'h0E, 0, 0, 18);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
